rv32_ahb_access_sequencer: RTL and testbench

Sequences the RV32IM core's two memory requesters, instruction fetch and load/store, onto the single unified AHB-Lite SRAM bus. It arbitrates per address phase, tracks the pipelined address and data phases, and holds the bus stable during wait states. It routes HRDATA and HRESP back to the owning requester. It sits between the core datapath and the SoC AHB-Lite interconnect, and replaces the combinational fetch/data mux.

---
 rtl/rv32_ahb_access_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_rv32_ahb_access_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rv32_ahb_access_sequencer.sv
// -----------------------------------------------------------------------------
// rv32_ahb_access_sequencer
//
// Puts the RV32IM core's instruction-fetch and load/store requesters onto one
// AHB-Lite bus. A new address phase is arbitrated in every cycle where HREADY is
// high. Data requests win unless fetch has been held off for STARVE_LIMIT data
// grants in a row. The accepted address phase moves into the data phase, and
// the completing data phase returns HRDATA/HRESP to whichever requester owns it.
// During wait states the address phase registers keep the bus stable.
//
// Optional feature macro: RV32_AHB_ALIGN_CHECK_EN
//   When defined, a misaligned half or word data request is granted but not
//   issued on the bus (HTRANS = IDLE). A phantom data phase then completes with
//   d_err = 1 and d_rdata = 0.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   if_req/if_addr              fetch request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata/if_err   fetch grant and response
//   d_req/d_addr/d_we/d_size/d_wdata   load/store request (held until d_gnt)
//   d_gnt/d_rvalid/d_rdata/d_err       load/store grant and response
//   HADDR/HTRANS/HWRITE/HSIZE/HWDATA   AHB-Lite master outputs
//   HRDATA/HREADY/HRESP                AHB-Lite slave responses
// -----------------------------------------------------------------------------
module rv32_ahb_access_sequencer #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [XLEN-1:0] if_rdata,
    output logic            if_err,
    input  logic            d_req,
    input  logic [XLEN-1:0] d_addr,
    input  logic            d_we,
    input  logic [2:0]      d_size,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [XLEN-1:0] d_rdata,
    output logic            d_err,
    output logic [XLEN-1:0] HADDR,
    output logic [1:0]      HTRANS,
    output logic            HWRITE,
    output logic [2:0]      HSIZE,
    output logic [XLEN-1:0] HWDATA,
    input  logic [XLEN-1:0] HRDATA,
    input  logic            HREADY,
    input  logic            HRESP
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [3:0] LIMIT         = 4'(STARVE_LIMIT);

    typedef enum logic {SRC_IF = 1'b0, SRC_D = 1'b1} src_e;

    // Address phase as currently driven (kept for wait states)
    logic [1:0]      ap_trans_q, ap_trans_d;
    logic [XLEN-1:0] ap_addr_q,  ap_addr_d;
    logic            ap_write_q, ap_write_d;
    logic [2:0]      ap_size_q,  ap_size_d;

    // Data phase in flight
    logic            dp_valid_q,   dp_valid_d;
    src_e            dp_src_q,     dp_src_d;
    logic            dp_write_q,   dp_write_d;
    logic [XLEN-1:0] dp_wdata_q,   dp_wdata_d;
    logic            dp_phantom_q, dp_phantom_d;

    // Consecutive data grants while fetch waits
    logic [3:0]      cnt_q, cnt_d;

    logic            fetch_wins_s;
    logic            d_misaligned_s;

`ifdef RV32_AHB_ALIGN_CHECK_EN
    function automatic logic misaligned(input logic [2:0] size, input logic [1:0] lsb);
        case (size)
            3'd1:    return lsb[0];
            3'd2:    return (lsb != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    // Misaligned half/word data requests become phantom transfers
    assign d_misaligned_s = misaligned(d_size, d_addr[1:0]);
`else
    // No alignment checking: every data request goes on the bus as-is
    assign d_misaligned_s = 1'b0;
`endif

    // Arbitration, bus drive, completion routing and next-state logic
    always_comb begin
        if_gnt       = 1'b0;
        if_rvalid    = 1'b0;
        if_rdata     = '0;
        if_err       = 1'b0;
        d_gnt        = 1'b0;
        d_rvalid     = 1'b0;
        d_rdata      = '0;
        d_err        = 1'b0;
        HADDR        = '0;
        HTRANS       = HTRANS_IDLE;
        HWRITE       = 1'b0;
        HSIZE        = 3'b000;
        HWDATA       = '0;
        fetch_wins_s = 1'b0;
        ap_trans_d   = ap_trans_q;
        ap_addr_d    = ap_addr_q;
        ap_write_d   = ap_write_q;
        ap_size_d    = ap_size_q;
        dp_valid_d   = dp_valid_q;
        dp_src_d     = dp_src_q;
        dp_write_d   = dp_write_q;
        dp_wdata_d   = dp_wdata_q;
        dp_phantom_d = dp_phantom_q;
        cnt_d        = cnt_q;

        if (!rst_n) begin
            // Outputs stay at reset values so an in-flight transfer never
            // reports rvalid; the flops themselves clear in the register block.
            cnt_d = 4'd0;
        end else begin
            // Completing data phase: route the response to its owner
            if (dp_valid_q && HREADY) begin
                if (dp_src_q == SRC_IF) begin
                    if_rvalid = 1'b1;
                    if_rdata  = HRDATA;
                    if_err    = HRESP;
                end else begin
                    d_rvalid = 1'b1;
                    d_err    = dp_phantom_q ? 1'b1 : HRESP;
                    d_rdata  = (dp_write_q || dp_phantom_q) ? '0 : HRDATA;
                end
            end else begin
                if_rvalid = 1'b0;
            end

            HWDATA = (dp_valid_q && dp_write_q && !dp_phantom_q) ? dp_wdata_q : '0;

            if (HREADY) begin
                fetch_wins_s = if_req && (!d_req || (cnt_q == LIMIT));
                if (fetch_wins_s) begin
                    if_gnt       = 1'b1;
                    ap_trans_d   = HTRANS_NONSEQ;
                    ap_addr_d    = if_addr;
                    ap_write_d   = 1'b0;
                    ap_size_d    = HSIZE_WORD;
                    dp_valid_d   = 1'b1;
                    dp_src_d     = SRC_IF;
                    dp_write_d   = 1'b0;
                    dp_wdata_d   = '0;
                    dp_phantom_d = 1'b0;
                end else if (d_req) begin
                    d_gnt        = 1'b1;
                    ap_trans_d   = d_misaligned_s ? HTRANS_IDLE : HTRANS_NONSEQ;
                    ap_addr_d    = d_addr;
                    ap_write_d   = d_we;
                    ap_size_d    = d_size;
                    dp_valid_d   = 1'b1;
                    dp_src_d     = SRC_D;
                    dp_write_d   = d_we;
                    dp_wdata_d   = d_wdata;
                    dp_phantom_d = d_misaligned_s;
                end else begin
                    ap_trans_d   = HTRANS_IDLE;
                    ap_addr_d    = '0;
                    ap_write_d   = 1'b0;
                    ap_size_d    = 3'b000;
                    dp_valid_d   = 1'b0;
                    dp_src_d     = SRC_IF;
                    dp_write_d   = 1'b0;
                    dp_wdata_d   = '0;
                    dp_phantom_d = 1'b0;
                end

                // Fairness: count data grants only while fetch is waiting
                if (!if_req || if_gnt) begin
                    cnt_d = 4'd0;
                end else if (d_gnt && (cnt_q != LIMIT)) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    cnt_d = cnt_q;
                end
            end else begin
                // Wait state: everything holds, bus re-driven from AP registers
                cnt_d = cnt_q;
            end

            HADDR  = ap_addr_d;
            HTRANS = ap_trans_d;
            HWRITE = ap_write_d;
            HSIZE  = ap_size_d;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ap_trans_q   <= HTRANS_IDLE;
            ap_addr_q    <= '0;
            ap_write_q   <= 1'b0;
            ap_size_q    <= 3'b000;
            dp_valid_q   <= 1'b0;
            dp_src_q     <= SRC_IF;
            dp_write_q   <= 1'b0;
            dp_wdata_q   <= '0;
            dp_phantom_q <= 1'b0;
            cnt_q        <= 4'd0;
        end else begin
            ap_trans_q   <= ap_trans_d;
            ap_addr_q    <= ap_addr_d;
            ap_write_q   <= ap_write_d;
            ap_size_q    <= ap_size_d;
            dp_valid_q   <= dp_valid_d;
            dp_src_q     <= dp_src_d;
            dp_write_q   <= dp_write_d;
            dp_wdata_q   <= dp_wdata_d;
            dp_phantom_q <= dp_phantom_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_rv32_ahb_access_sequencer.sv
// -----------------------------------------------------------------------------
// Randomized self-checking bench for rv32_ahb_access_sequencer. Two requester
// models hold their requests until granted; the slave side drives random
// HREADY/HRDATA/HRESP. A transaction-level reference model predicts grants,
// bus contents and responses each cycle.
// -----------------------------------------------------------------------------
module tb_rv32_ahb_access_sequencer;

    localparam int XLEN  = 32;
    localparam int LIMIT = 4;
    localparam int NCYC  = 4000;

    logic            clk;
    logic            rst_n;
    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic            if_gnt, if_rvalid, if_err;
    logic [XLEN-1:0] if_rdata;
    logic            d_req, d_we;
    logic [XLEN-1:0] d_addr, d_wdata;
    logic [2:0]      d_size;
    logic            d_gnt, d_rvalid, d_err;
    logic [XLEN-1:0] d_rdata;
    logic [XLEN-1:0] HADDR, HWDATA, HRDATA;
    logic [1:0]      HTRANS;
    logic            HWRITE, HREADY, HRESP;
    logic [2:0]      HSIZE;

    rv32_ahb_access_sequencer #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_size(d_size),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .d_err(d_err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (time %0t)", tag, got, exp, $time);
        end
    endtask

    // A request the bus has accepted but not yet answered
    typedef struct {
        bit          is_fetch;
        bit          write;
        bit          phantom;
        logic [31:0] wdata;
    } xfer_t;

    xfer_t       inflight[$];   // at most one entry: the data phase
    int          m_fairness;    // data grants since fetch started waiting
    logic [1:0]  last_trans;    // bus as last driven, re-shown during waits
    logic [31:0] last_addr;
    logic        last_write;
    logic [2:0]  last_size;

    // Expected outputs for the current cycle
    logic        e_if_gnt, e_if_rvalid, e_if_err, e_d_gnt, e_d_rvalid, e_d_err;
    logic [31:0] e_if_rdata, e_d_rdata, e_haddr, e_hwdata;
    logic [1:0]  e_htrans;
    logic        e_hwrite;
    logic [2:0]  e_hsize;
    bit          e_mis;

    bit if_pend, d_pend;

    function automatic bit is_mis(input logic [2:0] size, input logic [31:0] addr);
`ifdef RV32_AHB_ALIGN_CHECK_EN
        if (size == 3'd1) return addr[0];
        if (size == 3'd2) return addr[1:0] != 2'b00;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        inflight.delete();
        m_fairness = 0;
        last_trans = 2'b00;
        last_addr  = 32'h0;
        last_write = 1'b0;
        last_size  = 3'd0;
    endtask

    // Predict this cycle's outputs from the current inputs and model state
    task automatic predict();
        e_if_gnt = 0; e_if_rvalid = 0; e_if_err = 0; e_if_rdata = 32'h0;
        e_d_gnt = 0; e_d_rvalid = 0; e_d_err = 0; e_d_rdata = 32'h0;
        e_haddr = 32'h0; e_hwdata = 32'h0; e_htrans = 2'b00; e_hwrite = 0; e_hsize = 3'd0;
        e_mis = 0;
        if (rst_n) begin
            if (inflight.size() > 0) begin
                if (inflight[0].write && !inflight[0].phantom) e_hwdata = inflight[0].wdata;
                if (HREADY) begin
                    if (inflight[0].is_fetch) begin
                        e_if_rvalid = 1; e_if_rdata = HRDATA; e_if_err = HRESP;
                    end else begin
                        e_d_rvalid = 1;
                        e_d_err    = inflight[0].phantom ? 1'b1 : HRESP;
                        e_d_rdata  = (inflight[0].write || inflight[0].phantom) ? 32'h0 : HRDATA;
                    end
                end
            end
            if (HREADY) begin
                if (if_req && (!d_req || m_fairness >= LIMIT)) begin
                    e_if_gnt = 1; e_htrans = 2'b10; e_haddr = if_addr; e_hsize = 3'd2;
                end else if (d_req) begin
                    e_d_gnt = 1; e_mis = is_mis(d_size, d_addr);
                    e_htrans = e_mis ? 2'b00 : 2'b10;
                    e_haddr = d_addr; e_hwrite = d_we; e_hsize = d_size;
                end
            end else begin
                e_htrans = last_trans; e_haddr = last_addr;
                e_hwrite = last_write; e_hsize = last_size;
            end
        end
    endtask

    // Advance the model across the rising edge
    task automatic advance();
        xfer_t x;
        if (!rst_n) begin
            model_reset();
        end else if (HREADY) begin
            inflight.delete();
            if (e_if_gnt || e_d_gnt) begin
                x.is_fetch = e_if_gnt;
                x.write    = e_d_gnt && d_we;
                x.phantom  = e_mis;
                x.wdata    = e_d_gnt ? d_wdata : 32'h0;
                inflight.push_back(x);
            end
            last_trans = e_htrans; last_addr = e_haddr;
            last_write = e_hwrite; last_size = e_hsize;
            if (!if_req || e_if_gnt) m_fairness = 0;
            else if (e_d_gnt && m_fairness < LIMIT) m_fairness = m_fairness + 1;
        end
    endtask

    task automatic compare_all();
        check_eq("if_gnt",    32'(if_gnt),    32'(e_if_gnt));
        check_eq("if_rvalid", 32'(if_rvalid), 32'(e_if_rvalid));
        check_eq("if_rdata",  if_rdata,       e_if_rdata);
        check_eq("if_err",    32'(if_err),    32'(e_if_err));
        check_eq("d_gnt",     32'(d_gnt),     32'(e_d_gnt));
        check_eq("d_rvalid",  32'(d_rvalid),  32'(e_d_rvalid));
        check_eq("d_rdata",   d_rdata,        e_d_rdata);
        check_eq("d_err",     32'(d_err),     32'(e_d_err));
        check_eq("HADDR",     HADDR,          e_haddr);
        check_eq("HTRANS",    32'(HTRANS),    32'(e_htrans));
        check_eq("HWRITE",    32'(HWRITE),    32'(e_hwrite));
        check_eq("HSIZE",     32'(HSIZE),     32'(e_hsize));
        check_eq("HWDATA",    HWDATA,         e_hwdata);
    endtask

    initial begin
        int p_ready, p_if, p_d, phase;
        rst_n = 1'b0; if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_addr = 32'h0;
        d_we = 1'b0; d_size = 3'd0; d_wdata = 32'h0;
        HRDATA = 32'h0; HREADY = 1'b1; HRESP = 1'b0;
        if_pend = 0; d_pend = 0;
        model_reset();

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            // Phases: starvation stress, zero-wait mix, heavy waits, sparse traffic
            phase = (cyc / 250) % 4;
            case (phase)
                0:       begin p_ready = 100; p_if = 100; p_d = 100; end
                1:       begin p_ready = 100; p_if = 60;  p_d = 60;  end
                2:       begin p_ready = 50;  p_if = 70;  p_d = 70;  end
                default: begin p_ready = 80;  p_if = 25;  p_d = 25;  end
            endcase
            rst_n = (cyc < 3) ? 1'b0 : ($urandom_range(99) != 0);
            if (!if_pend && $urandom_range(99) < p_if) begin
                if_pend = 1;
                if_addr = {$urandom(), 2'b00} & 32'hFFFF_FFFC;
            end
            if (!d_pend && $urandom_range(99) < p_d) begin
                d_pend  = 1;
                d_addr  = $urandom();
                d_we    = $urandom_range(1) == 1;
                d_size  = 3'($urandom_range(2));
                d_wdata = $urandom();
            end
            if_req = if_pend;
            d_req  = d_pend;
            HREADY = $urandom_range(99) < p_ready;
            HRESP  = $urandom_range(7) == 0;
            HRDATA = $urandom();
            #1;
            predict();
            compare_all();
            @(posedge clk);
            advance();
            if (e_if_gnt) if_pend = 0;
            if (e_d_gnt)  d_pend  = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
